depth_test_unit: RTL and testbench
==================================

DEPTH_TEST_UNIT -- requirements
Module: depth_test_unit

Interface
REQ-001 clock  in  1  single clock; all state updates on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 addr_in  in  26  pixel address of the fragment (frame-buffer base + y*640 + x).
REQ-004 color_in  in  24  fragment RGB.
REQ-005 depth_in  in  32  fragment depth, unsigned; smaller is nearer.
REQ-006 in_valid  in  1  fragment present on addr_in/color_in/depth_in.
REQ-007 done_in  in  1  upstream has emitted its last fragment.
REQ-008 stall_out  out  1  fragment not accepted this cycle; upstream holds its inputs.
REQ-009 done_out  out  1  all fragments retired after done_in.
REQ-010 mem_addr  out  26  word address to the shared frame/Z memory.
REQ-011 mem_read / mem_write  out  1 each  request strobes; never both high.
REQ-012 mem_wdata  out  32  write data.
REQ-013 mem_rdata  in  32  read data.
REQ-014 mem_waitrequest  in  1  request not taken; hold address, data and strobes.
REQ-015 mem_rdata_valid  in  1  mem_rdata valid this cycle.

Function
REQ-016 Acceptance: fragment captured into the input register when in_valid=1 and stall_out=0.
REQ-017 stall_out=1 whenever the FSM is not in IDLE, or while reset is asserted.
REQ-018 FSM states: IDLE, RD_Z, WAIT_Z, WR_Z, WR_C, DONE.
REQ-019 IDLE -> RD_Z on acceptance; IDLE -> DONE when done_in=1, in_valid=0 and no fragment is held.
REQ-020 RD_Z: mem_read=1 and mem_addr=addr+ZBUF_OFFSET (26-bit wrap). Move to WAIT_Z on the first cycle with mem_waitrequest=0.
REQ-021 WAIT_Z: on mem_rdata_valid, compare depth_in against mem_rdata, unsigned. If depth_in < stored, go to WR_Z. Otherwise go to IDLE and drop the fragment. Equal depth drops the fragment.
REQ-022 WR_Z: mem_write=1, mem_addr=addr+ZBUF_OFFSET, mem_wdata=depth. Move to WR_C when mem_waitrequest=0.
REQ-023 WR_C: mem_write=1, mem_addr=addr, mem_wdata={8'h00,color}. Move to IDLE when mem_waitrequest=0.
REQ-024 Minimum latency with zero wait states: accept to color write = 4 cycles (RD_Z, WAIT_Z with read latency 1, WR_Z, WR_C). Throughput is one fragment per 5 cycles, including the return to IDLE.
REQ-025 While waitrequest=1, mem_addr, mem_wdata and the strobes are held stable.
REQ-026 done_out is sticky in DONE, and rises only after the final WR_C or drop has completed. DONE exits to IDLE when done_in=0.
REQ-027 done_in arriving together with an accepted fragment: that fragment completes first, then the FSM enters DONE.
REQ-028 mem_rdata_valid outside WAIT_Z is ignored.

Reset
REQ-029 Reset state: FSM=IDLE; stall_out=1 while reset is asserted, 0 after release; mem_read=mem_write=0; mem_addr=0; mem_wdata=0; done_out=0; input register cleared.
REQ-030 Reset during any memory transaction abandons it. The first post-reset cycle issues no strobe.

Configuration
REQ-031 Macro DEPTH_TEST_UNIT_ZTEST_EN.
- Defined: behaviour as in REQ-020 to REQ-023.
- Undefined: RD_Z, WAIT_Z and WR_Z are removed. Every fragment goes IDLE -> WR_C and the color write is unconditional. Latency is 1 cycle and mem_read stays 0.

Structure
REQ-032 Package gfx_pkg holds:
- SCREEN_W=640, SCREEN_H=480;
- ZBUF_OFFSET=26'h0100000;
- typedef fragment_t {addr[25:0], color[23:0], depth[31:0]};
- enum dtu_state_t.
REQ-033 Sub-module dtu_mem_req provides the request holding register. It holds addr/wdata/strobes until waitrequest deasserts.

Verification
REQ-034 Nearer fragment: Z memory at 0x0100064 = 0x00008000; fragment addr=0x64, depth=0x00004000, color=0xFF0000, zero wait.
-> read 0x0100064, write 0x00004000 to 0x0100064, write 0x00FF0000 to 0x64; stall_out low again on cycle 5.
REQ-035 Farther and equal fragments: stored depth=0x4000; fragments with depth 0x5000, then 0x4000.
-> one read each, no mem_write; both dropped.
REQ-036 Wait states: waitrequest=1 for 3 cycles on each request.
-> mem_addr and mem_wdata stable throughout; each transaction completes once; no duplicate strobes.
REQ-037 Back-to-back input with in_valid held high: two fragments at addr 0x0 and 0x1.
-> second is accepted only after the first's WR_C completes; stall_out=1 in between.
REQ-038 done_in with the last fragment, and reset mid-transaction:
- done_in=1 with the last fragment -> done_out=1 one cycle after its WR_C completes.
- reset asserted during WR_Z -> mem_write=0 immediately, FSM=IDLE, no WR_C issued.
REQ-039 Macro undefined: any fragment -> single write {8'h00,color} to addr, 1-cycle latency, mem_read never asserted.

Source files
------------

// File: rtl/depth_test_unit_pkg.sv
// ----------------------------------------------------------------------------
// gfx_pkg
// Shared definitions for the depth test unit:
//   SCREEN_W / SCREEN_H : frame geometry (pixel address = base + y*640 + x)
//   ZBUF_OFFSET         : Z buffer sits this many words above the colour buffer
//   fragment_t          : captured fragment {addr, color, depth}
//   dtu_state_t         : depth test FSM states
//   zbuf_addr()         : pixel address -> Z buffer address (26-bit wrap)
//   color_word()        : RGB -> memory word {8'h00, rgb}
// ----------------------------------------------------------------------------
package gfx_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    localparam logic [25:0] ZBUF_OFFSET = 26'h0100000;

    typedef struct packed {
        logic [25:0] addr;
        logic [23:0] color;
        logic [31:0] depth;
    } fragment_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_Z,
        WAIT_Z,
        WR_Z,
        WR_C,
        DONE
    } dtu_state_t;

    // Sum is truncated to 26 bits, so addresses near the top wrap around.
    function automatic logic [25:0] zbuf_addr(input logic [25:0] pixel_addr);
        return pixel_addr + ZBUF_OFFSET;
    endfunction

    function automatic logic [31:0] color_word(input logic [23:0] color);
        return {8'h00, color};
    endfunction

endpackage

// File: rtl/depth_test_unit_if.sv
// ----------------------------------------------------------------------------
// depth_test_unit_if
// Request/response bus to the shared frame/Z memory (waitrequest style).
//   mem_addr        : word address
//   mem_read        : read strobe
//   mem_write       : write strobe (never together with mem_read)
//   mem_wdata       : write data
//   mem_rdata       : read data
//   mem_waitrequest : request not taken; requester holds everything stable
//   mem_rdata_valid : mem_rdata valid this cycle
// Modports: master = requester (depth test unit), slave = memory.
// ----------------------------------------------------------------------------
interface depth_test_unit_if;

    logic [25:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_waitrequest;
    logic        mem_rdata_valid;

    modport master (
        output mem_addr,
        output mem_read,
        output mem_write,
        output mem_wdata,
        input  mem_rdata,
        input  mem_waitrequest,
        input  mem_rdata_valid
    );

    modport slave (
        input  mem_addr,
        input  mem_read,
        input  mem_write,
        input  mem_wdata,
        output mem_rdata,
        output mem_waitrequest,
        output mem_rdata_valid
    );

endinterface

// File: rtl/depth_test_unit_mem_req.sv
// ----------------------------------------------------------------------------
// dtu_mem_req
// Request holding register for the memory bus. A new request is loaded when
// no request is outstanding or the outstanding one is being taken this cycle;
// while mem_waitrequest is high the outstanding request is frozen.
//   clock, reset        : clock, async active-high reset
//   load                : present req_* as the next request
//   req_addr/req_wdata  : next request address / write data
//   req_read/req_write  : next request strobes
//   mem_waitrequest     : memory has not taken the current request
//   mem_addr/mem_wdata  : registered request address / data
//   mem_read/mem_write  : registered request strobes
// ----------------------------------------------------------------------------
module dtu_mem_req (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [25:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        mem_waitrequest,
    output logic [25:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write
);

    logic pending;

    assign pending = mem_read | mem_write;

    // Hold while the memory stalls us; otherwise take the next request or
    // drop the strobes. Address/data are left as-is when idle, since only
    // the strobes qualify them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else if (pending && mem_waitrequest) begin
            mem_addr  <= mem_addr;
            mem_wdata <= mem_wdata;
            mem_read  <= mem_read;
            mem_write <= mem_write;
        end else if (load) begin
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            mem_read  <= req_read;
            mem_write <= req_write & ~req_read;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

endmodule

// File: rtl/depth_test_unit.sv
// ----------------------------------------------------------------------------
// depth_test_unit
// Per-fragment Z test: reads the stored depth, and if the fragment is nearer
// writes the new depth and then the colour; otherwise drops the fragment.
// Optional feature macro: DEPTH_TEST_UNIT_ZTEST_EN
//   defined   : full read/compare/write-Z/write-colour sequence
//   undefined : every fragment goes straight to an unconditional colour write
// Ports:
//   clock, reset            : clock, async active-high reset
//   addr_in/color_in/depth_in, in_valid : fragment from upstream
//   done_in                 : upstream has sent its last fragment
//   stall_out               : fragment not accepted this cycle
//   done_out                : all fragments retired after done_in (sticky)
//   mem                     : memory bus (depth_test_unit_if.master)
// ----------------------------------------------------------------------------
module depth_test_unit
    import gfx_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [25:0]               addr_in,
    input  logic [23:0]               color_in,
    input  logic [31:0]               depth_in,
    input  logic                      in_valid,
    input  logic                      done_in,
    output logic                      stall_out,
    output logic                      done_out,
    depth_test_unit_if.master         mem
);

    dtu_state_t  state;
    fragment_t   frag;
    logic        done_pending;

    logic        req_load;
    logic [25:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_read;
    logic        req_write;

    // Upstream may only hand over a fragment while we sit in IDLE; reset is
    // folded in so the stall is visible even before the first clock edge.
    assign stall_out = reset | (state != IDLE);

`ifdef DEPTH_TEST_UNIT_ZTEST_EN
    logic nearer;

    // Strictly less: an equal depth loses to what is already in the buffer.
    assign nearer = frag.depth < mem.mem_rdata;
`else
    logic unused_ztest;

    assign unused_ztest = ^{frag.depth, mem.mem_rdata, mem.mem_rdata_valid};
`endif

    // Next memory request. Loads happen on the edge that leaves the previous
    // step, so each strobe appears in the same cycle as its FSM state.
    always_comb begin
        req_load  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_read  = 1'b0;
        req_write = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    req_load = 1'b1;
`ifdef DEPTH_TEST_UNIT_ZTEST_EN
                    req_addr = zbuf_addr(addr_in);
                    req_read = 1'b1;
`else
                    req_addr  = addr_in;
                    req_wdata = color_word(color_in);
                    req_write = 1'b1;
`endif
                end
            end
`ifdef DEPTH_TEST_UNIT_ZTEST_EN
            WAIT_Z: begin
                if (mem.mem_rdata_valid && nearer) begin
                    req_load  = 1'b1;
                    req_addr  = zbuf_addr(frag.addr);
                    req_wdata = frag.depth;
                    req_write = 1'b1;
                end
            end
            WR_Z: begin
                if (!mem.mem_waitrequest) begin
                    req_load  = 1'b1;
                    req_addr  = frag.addr;
                    req_wdata = color_word(frag.color);
                    req_write = 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // Main FSM. A fragment accepted together with done_in sets done_pending,
    // so DONE is entered only once that fragment has been written or dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            frag         <= '0;
            done_pending <= 1'b0;
            done_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        frag         <= '{addr: addr_in, color: color_in, depth: depth_in};
                        done_pending <= done_in;
`ifdef DEPTH_TEST_UNIT_ZTEST_EN
                        state        <= RD_Z;
`else
                        state        <= WR_C;
`endif
                    end else if (done_in) begin
                        state    <= DONE;
                        done_out <= 1'b1;
                    end
                end
`ifdef DEPTH_TEST_UNIT_ZTEST_EN
                RD_Z: begin
                    if (!mem.mem_waitrequest) begin
                        state <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (mem.mem_rdata_valid) begin
                        if (nearer) begin
                            state <= WR_Z;
                        end else begin
                            state        <= done_pending ? DONE : IDLE;
                            done_out     <= done_pending;
                            done_pending <= 1'b0;
                        end
                    end
                end
                WR_Z: begin
                    if (!mem.mem_waitrequest) begin
                        state <= WR_C;
                    end
                end
`endif
                WR_C: begin
                    if (!mem.mem_waitrequest) begin
                        state        <= done_pending ? DONE : IDLE;
                        done_out     <= done_pending;
                        done_pending <= 1'b0;
                    end
                end
                DONE: begin
                    if (!done_in) begin
                        state    <= IDLE;
                        done_out <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    dtu_mem_req u_mem_req (
        .clock           (clock),
        .reset           (reset),
        .load            (req_load),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_read        (req_read),
        .req_write       (req_write),
        .mem_waitrequest (mem.mem_waitrequest),
        .mem_addr        (mem.mem_addr),
        .mem_wdata       (mem.mem_wdata),
        .mem_read        (mem.mem_read),
        .mem_write       (mem.mem_write)
    );

endmodule

// File: tb/tb_depth_test_unit.sv
// ----------------------------------------------------------------------------
// tb_depth_test_unit
// Self-checking bench for depth_test_unit. Expected memory transactions are
// queued when a fragment is accepted and compared as the memory model takes
// each request. Builds with or without DEPTH_TEST_UNIT_ZTEST_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_depth_test_unit;

`ifdef DEPTH_TEST_UNIT_ZTEST_EN
    localparam bit ZTEST = 1'b1;
`else
    localparam bit ZTEST = 1'b0;
`endif

    localparam logic [25:0] ZOFF = 26'h0100000;

    typedef struct {
        bit          is_write;
        logic [25:0] addr;
        logic [31:0] data;
    } mem_txn_t;

    typedef struct {
        logic [25:0] addr;
        logic [23:0] color;
        logic [31:0] depth;
        bit          preload;
        logic [31:0] z_init;
        int          waits;
        bit          near;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [25:0] addr_in;
    logic [23:0] color_in;
    logic [31:0] depth_in;
    logic        in_valid;
    logic        done_in;
    logic        stall_out;
    logic        done_out;

    depth_test_unit_if mif();

    depth_test_unit dut (
        .clock     (clock),
        .reset     (reset),
        .addr_in   (addr_in),
        .color_in  (color_in),
        .depth_in  (depth_in),
        .in_valid  (in_valid),
        .done_in   (done_in),
        .stall_out (stall_out),
        .done_out  (done_out),
        .mem       (mif)
    );

    mem_txn_t    sb_q[$];
    logic [31:0] phys_mem [logic [25:0]];
    int          checks     = 0;
    int          errors     = 0;
    int          reads_seen = 0;
    int          exp_reads  = 0;
    int          wait_cfg   = 0;
    bit          noise_en   = 1'b0;
    vec_t        vecs [8];

    initial forever #5 clock = ~clock;

    // Hard stop in case the design locks up somewhere unbounded.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Cycles stall_out stays high after acceptance, counting from the accept edge.
    function automatic int expLatency(input bit near, input int w);
        if (!ZTEST) return 1 + w;
        return near ? (4 + 3 * w) : (2 + w);
    endfunction

    task automatic pushExpect(input logic [25:0] a, input logic [23:0] c, input logic [31:0] d, input bit near);
        mem_txn_t t;
        if (ZTEST) begin
            t.is_write = 1'b0; t.addr = a + ZOFF; t.data = '0;
            sb_q.push_back(t);
            exp_reads++;
            if (near) begin
                t.is_write = 1'b1; t.addr = a + ZOFF; t.data = d;
                sb_q.push_back(t);
                t.is_write = 1'b1; t.addr = a; t.data = {8'h00, c};
                sb_q.push_back(t);
            end
        end else begin
            t.is_write = 1'b1; t.addr = a; t.data = {8'h00, c};
            sb_q.push_back(t);
        end
    endtask

    // Present a fragment, wait (bounded) until it is taken, queue its expected
    // transactions. 'waited' = negedges seen with stall_out high beforehand.
    task automatic applyStimulus(input logic [25:0] a, input logic [23:0] c, input logic [31:0] d,
                                 input bit near, input bit dn, input bit keep, output int waited);
        addr_in  = a;
        color_in = c;
        depth_in = d;
        in_valid = 1'b1;
        done_in  = dn;
        waited   = 0;
        while (stall_out === 1'b1 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (stall_out !== 1'b0) checkOutput("accept_timeout", 64'(stall_out), 64'(0));
        checkOutput("prev_drained", 64'(sb_q.size()), 64'(0));
        pushExpect(a, c, d, near);
        @(posedge clock);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        @(negedge clock);
        while (stall_out === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clock);
        end
        if (stall_out !== 1'b0) checkOutput("idle_timeout", 64'(stall_out), 64'(0));
    endtask

    // Memory model: decides waitrequest mid-cycle, checks held requests stay
    // stable, retires each taken request against the scoreboard and returns
    // read data one cycle after the read is taken.
    initial begin
        logic [59:0] held;
        logic [59:0] cur;
        int          wait_left;
        bit          busy;
        bit          rd_pending;
        logic [31:0] rd_data;
        mem_txn_t    exp;
        busy = 1'b0; rd_pending = 1'b0; rd_data = '0; wait_left = 0; held = '0;
        mif.mem_waitrequest = 1'b0;
        mif.mem_rdata_valid = 1'b0;
        mif.mem_rdata       = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy = 1'b0;
                rd_pending = 1'b0;
                mif.mem_waitrequest = 1'b0;
                mif.mem_rdata_valid = 1'b0;
            end else begin
                mif.mem_rdata_valid = rd_pending | noise_en;
                mif.mem_rdata       = rd_pending ? rd_data : 32'h0;
                rd_pending = 1'b0;
                cur = {mif.mem_read, mif.mem_write, mif.mem_addr, mif.mem_wdata};
                if (busy) checkOutput("hold_stable", 64'(cur), 64'(held));
                if (mif.mem_read || mif.mem_write) begin
                    checkOutput("strobe_excl", 64'(mif.mem_read & mif.mem_write), 64'(0));
                    if (!busy) begin
                        busy = 1'b1;
                        wait_left = wait_cfg;
                        held = cur;
                    end
                    if (wait_left > 0) begin
                        mif.mem_waitrequest = 1'b1;
                        wait_left--;
                    end else begin
                        mif.mem_waitrequest = 1'b0;
                        busy = 1'b0;
                        if (sb_q.size() == 0) begin
                            checkOutput("unexpected_txn", 64'(1), 64'(0));
                        end else begin
                            exp = sb_q.pop_front();
                            checkOutput("txn_kind", 64'(mif.mem_write), 64'(exp.is_write));
                            checkOutput("txn_addr", 64'(mif.mem_addr), 64'(exp.addr));
                            if (exp.is_write) checkOutput("txn_wdata", 64'(mif.mem_wdata), 64'(exp.data));
                        end
                        if (mif.mem_read) begin
                            reads_seen++;
                            rd_pending = 1'b1;
                            rd_data = phys_mem.exists(mif.mem_addr) ? phys_mem[mif.mem_addr] : 32'hFFFF_FFFF;
                        end else begin
                            phys_mem[mif.mem_addr] = mif.mem_wdata;
                        end
                    end
                end else begin
                    busy = 1'b0;
                    mif.mem_waitrequest = 1'b0;
                end
            end
        end
    end

    initial begin
        int          waited;
        int          lat;
        int          cycles;
        logic [25:0] za;

        // addr, color, depth, preload, z_init, waits, near (with Z test)
        vecs[0] = '{26'h0000064, 24'hFF0000, 32'h0000_4000, 1'b1, 32'h0000_8000, 0, 1'b1};
        vecs[1] = '{26'h0000064, 24'h00FF00, 32'h0000_5000, 1'b0, 32'h0,          0, 1'b0};
        vecs[2] = '{26'h0000064, 24'h0000FF, 32'h0000_4000, 1'b0, 32'h0,          0, 1'b0};
        vecs[3] = '{26'h0000064, 24'h00FF00, 32'h0000_3FFF, 1'b0, 32'h0,          0, 1'b1};
        vecs[4] = '{26'h0000200, 24'h123456, 32'h0000_0000, 1'b0, 32'h0,          3, 1'b1};
        vecs[5] = '{26'h0000200, 24'h654321, 32'h0000_0001, 1'b0, 32'h0,          3, 1'b0};
        vecs[6] = '{26'h3FFFFFF, 24'hABCDEF, 32'h0000_0010, 1'b0, 32'h0,          1, 1'b1};
        vecs[7] = '{26'h0012345, 24'h0F0F0F, 32'hFFFF_FFFF, 1'b0, 32'h0,          2, 1'b0};

        reset    = 1'b1;
        in_valid = 1'b0;
        done_in  = 1'b0;
        addr_in  = '0;
        color_in = '0;
        depth_in = '0;

        $display("[TB] reset state");
        repeat (2) @(negedge clock);
        checkOutput("rst_stall",    64'(stall_out),     64'(1));
        checkOutput("rst_read",     64'(mif.mem_read),  64'(0));
        checkOutput("rst_write",    64'(mif.mem_write), 64'(0));
        checkOutput("rst_addr",     64'(mif.mem_addr),  64'(0));
        checkOutput("rst_wdata",    64'(mif.mem_wdata), 64'(0));
        checkOutput("rst_done_out", 64'(done_out),      64'(0));
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post_rst_stall",  64'(stall_out), 64'(0));
        checkOutput("post_rst_strobe", 64'(mif.mem_read | mif.mem_write), 64'(0));

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) begin
            wait_cfg = vecs[i].waits;
            noise_en = (vecs[i].waits != 0);
            if (vecs[i].preload) begin
                za = vecs[i].addr + ZOFF;
                phys_mem[za] = vecs[i].z_init;
            end
            applyStimulus(vecs[i].addr, vecs[i].color, vecs[i].depth, vecs[i].near, 1'b0, 1'b0, waited);
            waitIdle(lat);
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(expLatency(vecs[i].near, vecs[i].waits)));
            checkOutput($sformatf("vec%0d_drain", i), 64'(sb_q.size()), 64'(0));
        end
        wait_cfg = 0;
        noise_en = 1'b0;

        $display("[TB] back-to-back with in_valid held");
        applyStimulus(26'h0000000, 24'h111111, 32'h0000_0100, 1'b1, 1'b0, 1'b1, waited);
        checkOutput("b2b_first_wait", 64'(waited), 64'(0));
        // Counted from #1 after the first accept edge, so one extra negedge.
        applyStimulus(26'h0000001, 24'h222222, 32'h0000_0100, 1'b1, 1'b0, 1'b0, waited);
        checkOutput("b2b_stall_span", 64'(waited), 64'(expLatency(1'b1, 0) + 1));
        waitIdle(lat);
        checkOutput("b2b_second_lat", 64'(lat), 64'(expLatency(1'b1, 0)));

        $display("[TB] done_in with last fragment");
        applyStimulus(26'h0000400, 24'h00ABCD, 32'h0000_0005, 1'b1, 1'b1, 1'b0, waited);
        cycles = 0;
        @(negedge clock);
        while (done_out !== 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clock);
        end
        checkOutput("done_delay", 64'(cycles), 64'(expLatency(1'b1, 0)));
        checkOutput("done_stall", 64'(stall_out), 64'(1));
        checkOutput("done_drain", 64'(sb_q.size()), 64'(0));
        repeat (3) @(negedge clock);
        checkOutput("done_sticky", 64'(done_out), 64'(1));
        done_in = 1'b0;
        @(negedge clock);
        checkOutput("done_release", 64'(done_out), 64'(0));
        checkOutput("done_release_stall", 64'(stall_out), 64'(0));

        $display("[TB] done_in alone");
        done_in = 1'b1;
        @(negedge clock);
        checkOutput("done_alone", 64'(done_out), 64'(1));
        checkOutput("done_alone_strobe", 64'(mif.mem_read | mif.mem_write), 64'(0));
        done_in = 1'b0;
        @(negedge clock);
        checkOutput("done_alone_release", 64'(done_out), 64'(0));

        $display("[TB] reset during first write");
        wait_cfg = 3;
        applyStimulus(26'h0000300, 24'h0000EE, 32'h0000_0001, 1'b1, 1'b0, 1'b0, waited);
        cycles = 0;
        while (mif.mem_write !== 1'b1 && cycles < 50) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput("mid_write_seen", 64'(mif.mem_write), 64'(1));
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_write", 64'(mif.mem_write), 64'(0));
        checkOutput("mid_rst_read",  64'(mif.mem_read),  64'(0));
        checkOutput("mid_rst_stall", 64'(stall_out),     64'(1));
        @(negedge clock);
        checkOutput("mid_rst_abandoned", 64'(sb_q.size()), 64'(ZTEST ? 2 : 1));
        sb_q.delete();
        @(negedge clock);
        reset = 1'b0;
        wait_cfg = 0;
        @(negedge clock);
        checkOutput("mid_rst_idle",      64'(stall_out), 64'(0));
        checkOutput("mid_rst_no_strobe", 64'(mif.mem_read | mif.mem_write), 64'(0));
        checkOutput("mid_rst_done_out",  64'(done_out), 64'(0));

        $display("[TB] recovery after reset");
        applyStimulus(26'h0000300, 24'h0000EE, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, waited);
        waitIdle(lat);
        checkOutput("recover_latency", 64'(lat), 64'(expLatency(1'b1, 0)));
        checkOutput("recover_drain", 64'(sb_q.size()), 64'(0));

        checkOutput("read_count", 64'(reads_seen), 64'(exp_reads));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
